// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller.
// Optional feature macro: HAZARD_STATS_EN (statistics counters).
package hazard_pkg;

    // Controller states: normal issue, multi-cycle hazard stall, pipeline frozen
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    // Remaining-stall counter width; holds N-1 for N up to LOAD_LAT+1 = 8
    localparam int CNT_W = 3;
    // Stall-length width; N can reach LOAD_LAT+1 = 8
    localparam int N_W = 4;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 7;

    // Legal data-memory read latency range
    function automatic bit lat_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/hazard_ctrl_match.sv
// Per-source hazard match: compares one ID source register against the EX and
// MEM producers and returns the stall length that source alone would need.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  logic                  early,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wr,
    input  logic                  ex_ld,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_wr,
    input  logic                  mem_ld,
    output logic [N_W-1:0]        n
);

    localparam logic [N_W-1:0] LAT_N = N_W'(LOAD_LAT);

    logic           ex_hit;
    logic           mem_hit;
    logic [N_W-1:0] n_ex;
    logic [N_W-1:0] n_mem;

    // r0 is hardwired zero, so a write to it never creates a dependency
    assign ex_hit  = use_src && ex_wr  && (src == ex_rd)  && (ex_rd  != '0);
    assign mem_hit = use_src && mem_wr && (src == mem_rd) && (mem_rd != '0);

    // Stall length per producer; non-load results are forwarded to EX, so only
    // ID-resolved consumers wait for them
    always_comb begin
        n_ex  = '0;
        n_mem = '0;
        if (ex_hit && ex_ld)
            n_ex = early ? (LAT_N + N_W'(1)) : LAT_N;
        else if (ex_hit && early)
            n_ex = N_W'(1);
        if (mem_hit && mem_ld && early)
            n_mem = LAT_N;
        n = (n_ex > n_mem) ? n_ex : n_mem;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / early-branch stall generation with
// debug-run and memory-busy freeze. Optional statistics under HAZARD_STATS_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  du_run,
    input  logic                  du_stat_clr,
    input  logic                  mem_busy,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_early,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wr,
    input  logic                  ex_ld,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_wr,
    input  logic                  mem_ld,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  idex_bubble,
    output logic                  stall,
    output logic [STAT_W-1:0]     stat_stall_cyc,
    output logic [STAT_W-1:0]     stat_events
);

    if (!lat_ok(LOAD_LAT)) begin : g_lat_bad
        $error("hazard_ctrl: LOAD_LAT must be within 1..7");
    end

    state_t           state;
    state_t           ret_state;
    state_t           eff_state;
    logic [CNT_W-1:0] cnt;
    logic [N_W-1:0]   n_rs;
    logic [N_W-1:0]   n_rt;
    logic [N_W-1:0]   n;
    logic             freeze;
    logic             detect;
    logic             stall_act;

    hazard_match #(.REG_ADDR_W(REG_ADDR_W), .LOAD_LAT(LOAD_LAT)) u_match_rs (
        .src(id_rs), .use_src(id_use_rs), .early(id_early),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_ld(ex_ld),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ld(mem_ld),
        .n(n_rs)
    );

    hazard_match #(.REG_ADDR_W(REG_ADDR_W), .LOAD_LAT(LOAD_LAT)) u_match_rt (
        .src(id_rt), .use_src(id_use_rt), .early(id_early),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_ld(ex_ld),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ld(mem_ld),
        .n(n_rt)
    );

    assign n      = (n_rs > n_rt) ? n_rs : n_rt;
    assign freeze = !du_run || mem_busy;
    // While frozen the state register reads FREEZE; behaviour follows the
    // state that was interrupted so it resumes the cycle the freeze drops
    assign eff_state = (state == FREEZE) ? ret_state : state;
    assign detect    = !freeze && (eff_state == RUN) && (n != '0);
    assign stall_act = !freeze && ((eff_state == STALL) || detect);

    // Freeze holds everything without bubbling; a stall holds PC/IF-ID and bubbles
    always_comb begin
        stall       = stall_act;
        idex_bubble = stall_act;
        pc_we       = !freeze && !stall_act;
        ifid_we     = !freeze && !stall_act;
    end

    // Stall/freeze FSM with remaining-stall counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            ret_state <= RUN;
            cnt       <= '0;
        end else if (freeze) begin
            state     <= FREEZE;
            ret_state <= eff_state;
        end else begin
            case (eff_state)
                RUN: begin
                    if (detect) begin
                        cnt   <= CNT_W'(n - N_W'(1));
                        state <= (n > N_W'(1)) ? STALL : RUN;
                    end else begin
                        state <= RUN;
                    end
                end
                STALL: begin
                    cnt   <= cnt - CNT_W'(1);
                    state <= (cnt <= CNT_W'(1)) ? RUN : STALL;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_q;
    logic [STAT_W-1:0] ev_q;

    // Saturating stall-cycle and event counters; clear beats increment
    always_ff @(posedge clk) begin
        if (!rst || du_stat_clr) begin
            stall_q <= '0;
            ev_q    <= '0;
        end else begin
            if (stall_act && (stall_q != '1))
                stall_q <= stall_q + STAT_W'(1);
            if (detect && (ev_q != '1))
                ev_q <= ev_q + STAT_W'(1);
        end
    end

    assign stat_stall_cyc = stall_q;
    assign stat_events    = ev_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = du_stat_clr;
    assign stat_stall_cyc  = '0;
    assign stat_events     = '0;
`endif

endmodule
